// File: rtl/clk_div_monitor.sv
// Checks the ripple clock-divider outputs in the clk domain: measures each stage's
// half-period, tracks per-stage lock, and raises sticky period / stuck-at errors.
module clk_div_monitor #(
    parameter int NUM_STAGES  = 5,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_STAGES-1:0] div_in,
    input  logic                  err_clr,
    output logic [NUM_STAGES-1:0] locked,
    output logic [NUM_STAGES-1:0] err_period,
    output logic [NUM_STAGES-1:0] err_stuck,
    output logic                  all_locked
);
    localparam int CW = NUM_STAGES + 1;
    localparam int GW = 4;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    function automatic logic [CW-1:0] half_period(input int k);
        return CW'(1) << k;
    endfunction

    logic [NUM_STAGES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_STAGES-1:0] hist_q;
    logic [NUM_STAGES-1:0] edge_det;

    state_t           state_q [NUM_STAGES];
    state_t           state_d [NUM_STAGES];
    logic [CW-1:0]    cnt_q   [NUM_STAGES];
    logic [CW-1:0]    cnt_d   [NUM_STAGES];
    logic [GW-1:0]    good_q  [NUM_STAGES];
    logic [GW-1:0]    good_d  [NUM_STAGES];
    logic [NUM_STAGES-1:0] set_period;
    logic [NUM_STAGES-1:0] set_stuck;
    logic [NUM_STAGES-1:0] locked_d;

    // Synchronizer chain followed by one history flop; every stage sees the same delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= div_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            state_d[k]    = state_q[k];
            cnt_d[k]      = edge_det[k] ? CW'(1) : sat_inc(cnt_q[k]);
            good_d[k]     = good_q[k];
            set_period[k] = 1'b0;
            set_stuck[k]  = 1'b0;
            if (!en) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
                good_d[k]  = '0;
            end else begin
                case (state_q[k])
                    IDLE: begin
                        state_d[k] = ARM;
                        cnt_d[k]   = '0;
                        good_d[k]  = '0;
                    end
                    ARM: begin
                        if (edge_det[k]) state_d[k] = MEASURE;
                    end
                    default: begin
                        // Edge exactly at the expected count is a match; the count reaching
                        // the expected value without an edge means the input stopped.
                        if (edge_det[k]) begin
                            if (cnt_q[k] == half_period(k)) begin
                                if (state_q[k] == MEASURE) begin
                                    good_d[k] = good_q[k] + GW'(1);
                                    if (good_d[k] == GW'(LOCK_COUNT)) state_d[k] = LOCKED;
                                end
                            end else begin
                                set_period[k] = 1'b1;
                                good_d[k]     = '0;
                                state_d[k]    = MEASURE;
                            end
                        end else if (cnt_q[k] == half_period(k)) begin
                            set_stuck[k] = 1'b1;
                            good_d[k]    = '0;
                            state_d[k]   = ARM;
                        end
                    end
                endcase
            end
            locked_d[k] = (state_d[k] == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
                good_q[k]  <= '0;
            end
            locked     <= '0;
            err_period <= '0;
            err_stuck  <= '0;
            all_locked <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                good_q[k]  <= good_d[k];
            end
            locked     <= locked_d;
            err_period <= (err_period & ~{NUM_STAGES{err_clr}}) | set_period;
            err_stuck  <= (err_stuck  & ~{NUM_STAGES{err_clr}}) | set_stuck;
            // Needs lock both now and next cycle, so it rises one cycle after the last
            // stage locks but falls together with any locked bit.
            all_locked <= (&locked) & (&locked_d);
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: constant-expectation vector table, targeted corner
// sequences, and randomized divider faults checked against a timestamp model.
module tb_clk_div_monitor;
    localparam int NS = 5;
    localparam int LC = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          err_clr = 1'b0;
    logic [NS-1:0] div_in = '0;
    logic [NS-1:0] locked, err_period, err_stuck;
    logic          all_locked;

    clk_div_monitor #(.NUM_STAGES(NS), .LOCK_COUNT(LC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .err_clr(err_clr),
        .locked(locked), .err_period(err_period), .err_stuck(err_stuck),
        .all_locked(all_locked)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus: stage k outputs bit k of its own cycle counter dc[k]; freezing stops it.
    int            dc   [NS];
    int            fcnt [NS];
    logic [NS-1:0] frz;

    // Reference model: phase 0 idle, 1 waiting for first edge, 2 measuring, 3 locked.
    int            m_phase [NS];
    int            m_ref   [NS];
    int            m_good  [NS];
    logic [NS-1:0] m_locked, m_ep, m_es;
    logic          m_all;
    logic [NS-1:0] vh [SS+2];
    int            mcyc;

    typedef struct {
        int            cycles;
        logic          en;
        logic [NS-1:0] frz;
        logic          clr;
        logic [15:0]   exp;
    } vec_t;
    vec_t vecs [10];

    function automatic logic [15:0] mk(input logic [4:0] l, input logic [4:0] ep,
                                       input logic [4:0] es, input logic al);
        return {l, ep, es, al};
    endfunction

    function automatic logic [15:0] dut_out();
        return {locked, err_period, err_stuck, all_locked};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_phase[k] = 0;
            m_ref[k]   = 0;
            m_good[k]  = 0;
        end
        for (int j = 0; j < SS + 2; j++) vh[j] = '0;
        m_locked = '0;
        m_ep     = '0;
        m_es     = '0;
        m_all    = 1'b0;
        mcyc     = 0;
    endtask

    // The DUT sees an input change SS+1 clocks later; vh[j] holds div_in from j clocks ago.
    task automatic model_update();
        logic          prev_all;
        logic [NS-1:0] ev, sp, ss;
        int            el;
        for (int j = SS + 1; j > 0; j--) vh[j] = vh[j-1];
        vh[0]    = div_in;
        prev_all = &m_locked;
        ev       = vh[SS] ^ vh[SS+1];
        sp       = '0;
        ss       = '0;
        for (int k = 0; k < NS; k++) begin
            if (!en) begin
                m_phase[k] = 0;
                m_good[k]  = 0;
            end else if (m_phase[k] == 0) begin
                m_phase[k] = 1;
            end else if (m_phase[k] == 1) begin
                if (ev[k]) begin
                    m_ref[k]   = mcyc;
                    m_phase[k] = 2;
                end
            end else begin
                el = mcyc - m_ref[k];
                if (ev[k]) begin
                    if (el == (1 << k)) begin
                        if (m_phase[k] == 2) begin
                            m_good[k]++;
                            if (m_good[k] == LC) m_phase[k] = 3;
                        end
                    end else begin
                        sp[k]      = 1'b1;
                        m_good[k]  = 0;
                        m_phase[k] = 2;
                    end
                    m_ref[k] = mcyc;
                end else if (el == (1 << k)) begin
                    ss[k]      = 1'b1;
                    m_good[k]  = 0;
                    m_phase[k] = 1;
                end
            end
            m_locked[k] = (m_phase[k] == 3);
        end
        m_ep  = (m_ep & ~{NS{err_clr}}) | sp;
        m_es  = (m_es & ~{NS{err_clr}}) | ss;
        m_all = prev_all & (&m_locked);
        mcyc++;
    endtask

    function automatic logic pred_stuck(input int k);
        logic ev_next;
        ev_next = vh[SS-1][k] ^ vh[SS][k];
        return en && (m_phase[k] >= 2) && !ev_next && ((mcyc - m_ref[k]) == (1 << k));
    endfunction

    task automatic step();
        for (int k = 0; k < NS; k++) div_in[k] = dc[k][k];
        @(posedge clk);
        model_update();
        for (int k = 0; k < NS; k++) if (!frz[k]) dc[k]++;
        @(negedge clk);
        tests++;
        if (dut_out() !== {m_locked, m_ep, m_es, m_all}) begin
            fails++;
            $display("FAIL model cycle %0d: dut=0x%04h model=0x%04h", mcyc, dut_out(),
                     {m_locked, m_ep, m_es, m_all});
        end
        err_clr = 1'b0;
    endtask

    task automatic clear_stim();
        en      = 1'b0;
        err_clr = 1'b0;
        frz     = '0;
        for (int k = 0; k < NS; k++) begin
            dc[k]   = 0;
            fcnt[k] = 0;
        end
        model_reset();
    endtask

    task automatic lock_seq();
        int t0 = -1;
        int t4 = -1;
        en = 1'b1;
        for (int c = 1; c <= 100 && t4 < 0; c++) begin
            step();
            if (t0 < 0 && locked[0]) t0 = c;
            if (t4 < 0 && locked[4]) t4 = c;
        end
        chk("lock4_within_84", 32'(t4 > 0 && t4 <= 84), 32'(1));
        chk("lock0_before_lock4", 32'(t0 > 0 && t0 < t4), 32'(1));
        chk("all_locked_low_with_lock4", 32'(all_locked), 32'(0));
        step();
        chk("all_locked_next_cycle", 32'({all_locked, locked}), 32'({1'b1, 5'h1F}));
        repeat (1000) step();
        chk("no_err_1000", 32'({err_period, err_stuck}), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{5,    1'b0, 5'h00, 1'b0, mk(5'h00, 5'h00, 5'h00, 1'b0)};
        vecs[1] = '{90,   1'b1, 5'h00, 1'b0, mk(5'h1F, 5'h00, 5'h00, 1'b1)};
        vecs[2] = '{1000, 1'b1, 5'h00, 1'b0, mk(5'h1F, 5'h00, 5'h00, 1'b1)};
        vecs[3] = '{16,   1'b1, 5'h04, 1'b0, mk(5'h1B, 5'h00, 5'h04, 1'b0)};
        vecs[4] = '{60,   1'b1, 5'h00, 1'b0, mk(5'h1F, 5'h00, 5'h04, 1'b1)};
        vecs[5] = '{1,    1'b0, 5'h00, 1'b0, mk(5'h00, 5'h00, 5'h04, 1'b0)};
        vecs[6] = '{10,   1'b0, 5'h00, 1'b0, mk(5'h00, 5'h00, 5'h04, 1'b0)};
        vecs[7] = '{90,   1'b1, 5'h00, 1'b0, mk(5'h1F, 5'h00, 5'h04, 1'b1)};
        vecs[8] = '{1,    1'b1, 5'h00, 1'b1, mk(5'h1F, 5'h00, 5'h00, 1'b1)};
        vecs[9] = '{10,   1'b1, 5'h00, 1'b0, mk(5'h1F, 5'h00, 5'h00, 1'b1)};

        clear_stim();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(dut_out()), 32'(0));
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            en      = vecs[i].en;
            frz     = vecs[i].frz;
            err_clr = vecs[i].clr;
            repeat (vecs[i].cycles) step();
            chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
        end

        // Stage 2 stops toggling while everything is locked.
        frz[2] = 1'b1;
        n = -1;
        for (int i = 1; i <= 8 && n < 0; i++) begin
            step();
            if (err_stuck[2]) n = i;
        end
        chk("stuck2_within_8", 32'(n > 0), 32'(1));
        chk("stuck2_status", 32'({locked, err_stuck, all_locked}), 32'({5'h1B, 5'h04, 1'b0}));
        frz[2] = 1'b0;
        repeat (40) step();
        chk("relock_after_stuck", 32'(locked), 32'(5'h1F));

        // One 6-cycle half-period on stage 3.
        for (int i = 0; i < 16 && dc[3][2:0] != 3'd3; i++) step();
        dc[3] += 2;
        n = -1;
        for (int i = 1; i <= 12 && n < 0; i++) begin
            step();
            if (err_period[3]) n = i;
        end
        chk("period3_detect", 32'(n > 0), 32'(1));
        chk("period3_status", 32'({locked, err_period}), 32'({5'h17, 5'h08}));
        n = -1;
        for (int i = 1; i <= 50 && n < 0; i++) begin
            step();
            if (locked[3]) n = i;
        end
        chk("period3_relock_cycles", 32'(n), 32'(LC * 8));
        chk("period3_err_sticky", 32'(err_period), 32'(5'h08));

        // err_clr lands on the cycle a new stage-1 stuck error is decided.
        frz[1] = 1'b1;
        n = -1;
        for (int i = 1; i <= 12 && n < 0; i++) begin
            logic p;
            p = pred_stuck(1);
            err_clr = p;
            step();
            if (p) n = i;
        end
        chk("stuck1_coincident", 32'(n > 0), 32'(1));
        chk("clr_vs_set", 32'({err_period, err_stuck}), 32'({5'h00, 5'h02}));
        frz[1] = 1'b0;
        repeat (30) step();
        chk("relock_stage1", 32'(locked), 32'(5'h1F));

        // Enable drop while locked, then reacquire.
        en = 1'b0;
        step();
        chk("en_off_next_cycle", 32'(dut_out()), 32'(mk(5'h00, 5'h00, 5'h02, 1'b0)));
        en = 1'b1;
        n = -1;
        for (int i = 1; i <= 84 && n < 0; i++) begin
            step();
            if (locked == 5'h1F) n = i;
        end
        chk("relock_after_en_within_84", 32'(n > 0), 32'(1));

        // Asynchronous reset between clock edges.
        repeat (37) step();
        chk("pre_reset_err_stuck", 32'(err_stuck), 32'(5'h02));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_out()), 32'(0));
        clear_stim();
        @(negedge clk);
        rst = 1'b1;
        lock_seq();

        // Randomized enable, clears, freezes and phase jumps.
        for (int c = 0; c < 4000; c++) begin
            if (en) begin
                if ($urandom_range(399) == 0) en = 1'b0;
            end else if ($urandom_range(19) == 0) begin
                en = 1'b1;
            end
            err_clr = ($urandom_range(49) == 0);
            for (int k = 0; k < NS; k++) begin
                if (fcnt[k] > 0) fcnt[k]--;
                else if ($urandom_range(299) == 0) fcnt[k] = int'($urandom_range(30, 1));
                frz[k] = (fcnt[k] > 0);
                if ($urandom_range(299) == 0) dc[k] += int'($urandom_range(3, 1));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream checker for the ripple clock-divider chain (/2, /4, /8, /16, /32 outputs).
- Samples each divided clock in the clk domain and measures the half-period between toggles in clk cycles.
- Declares each stage locked after consecutive correct half-periods; flags sticky period and stuck-at faults.
- Feeds bring-up status and CSR logic.

Parameters:
- NUM_STAGES, 5: number of divided clocks monitored. Stage k expects half-period 2^k clk cycles (k=0 is /2).
- LOCK_COUNT, 4: consecutive matching half-periods required to assert locked[k]. Range 1..15.
- SYNC_STAGES, 2: flops in each input synchronizer. Minimum 2.

Ports:
- clk  input  1  monitor clock; the same clock that drives the divider chain.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  monitor enable; level-sensitive.
- div_in  input  NUM_STAGES  divided clocks; bit k = divide-by-2^(k+1).
- err_clr  input  1  one-cycle pulse; clears all sticky error bits.
- locked  output  NUM_STAGES  per-stage lock status, registered.
- err_period  output  NUM_STAGES  sticky: an edge arrived with the wrong half-period.
- err_stuck  output  NUM_STAGES  sticky: no edge by the time the expected half-period expired.
- all_locked  output  1  AND of locked, built from registered bits only.

Behaviour:
- Reset (rst=0, async): all synchronizer flops, edge-history flops, counters and FSMs are cleared. All outputs are 0.
- Input path:
  - Each div_in[k] passes through SYNC_STAGES flops, then one history flop.
  - edge[k] = sync_out XOR history. Both rising and falling edges count.
  - Latency from div_in change to edge[k] is SYNC_STAGES+1 cycles. It is identical for all stages, so measured periods are exact.
- Per-stage counter cnt[k], NUM_STAGES+1 bits, saturating:
  - On edge: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
- Per-stage FSM, states IDLE, ARM, MEASURE, LOCKED:
  - IDLE: entered on reset or whenever en=0. Counter and good count are held at 0. Goes to ARM when en=1.
  - ARM: waits for the first edge[k]. The first edge only starts the counter; no check is made. Then goes to MEASURE. No stuck check is done in ARM.
  - MEASURE: on edge, cnt==2^k is a match. A match increments good; when good reaches LOCK_COUNT, go to LOCKED. On edge with cnt!=2^k: set err_period[k], good <= 0, stay in MEASURE. With no edge and cnt==2^k: set err_stuck[k], good <= 0, go to ARM.
  - LOCKED: locked[k]=1. A mismatching edge sets err_period[k], drops locked, clears good and goes to MEASURE. A stuck timeout sets err_stuck[k], drops locked and goes to ARM.
  - locked[k] updates in the cycle after the deciding edge or timeout.
- en deassert mid-operation: next cycle all FSMs go to IDLE and locked clears. err_* bits are held.
- err_clr: clears all err_period and err_stuck bits. If set and clear happen in the same cycle, set wins for that bit.
- All stages run independently. A fault on one stage never affects another stage's locked bit.

Test Plan:
1. Reset, then en=1, div_in driven by an ideal ripple divider from clk. Required: locked[0] rises first and locked[4] rises last, within 2^4*(LOCK_COUNT+1)+SYNC_STAGES+2 = 84 cycles of en. all_locked=1 in the cycle after locked[4]. err_* stay 0 for 1000 cycles.
2. With the chain locked, hold div_in[2] constant. Required: err_stuck[2]=1 and locked[2]=0 within 4+SYNC_STAGES+2 cycles. All other locked bits stay 1. all_locked=0.
3. With the chain locked, force one half-period of div_in[3] to 6 cycles instead of 8. Required: err_period[3]=1 and locked[3] drops. After LOCK_COUNT further correct half-periods locked[3] returns to 1; err_period[3] stays 1 until err_clr.
4. Pulse err_clr in the same cycle a new stuck error on stage 1 is detected. Required: err_stuck[1] stays 1; all other err bits clear to 0.
5. Deassert en while all stages are locked. Required: locked=0 and all_locked=0 the next cycle; err bits unchanged. Reassert en: lock is reacquired within 84 cycles.
6. Assert rst asynchronously mid-measurement, between clk edges. Required: all outputs are 0 immediately. After release, behaviour matches scenario 1.
